sfx_tone_mixer: RTL



---
 rtl/sfx_tone_mixer_if.sv | 27 ++
 rtl/sfx_tone_mixer.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/sfx_tone_mixer_if.sv
// rtl/sfx_tone_mixer_if.sv - audio controller FIFO handshake and sample bus
interface sfx_tone_mixer_if #(
  parameter int SAMPLE_WIDTH = 32
);
  logic                    audio_in_available;
  logic                    audio_out_allowed;
  logic                    read_audio_in;
  logic                    write_audio_out;
  logic [SAMPLE_WIDTH-1:0] left_channel_audio_in;
  logic [SAMPLE_WIDTH-1:0] right_channel_audio_in;
  logic [SAMPLE_WIDTH-1:0] left_channel_audio_out;
  logic [SAMPLE_WIDTH-1:0] right_channel_audio_out;

  modport master (
    input  audio_in_available, audio_out_allowed,
    input  left_channel_audio_in, right_channel_audio_in,
    output read_audio_in, write_audio_out,
    output left_channel_audio_out, right_channel_audio_out
  );

  modport slave (
    output audio_in_available, audio_out_allowed,
    output left_channel_audio_in, right_channel_audio_in,
    input  read_audio_in, write_audio_out,
    input  left_channel_audio_out, right_channel_audio_out
  );
endinterface

// File: rtl/sfx_tone_mixer.sv
// rtl/sfx_tone_mixer.sv - gated multi-voice square tones summed into the codec stream
module sfx_tone_mixer #(
  parameter int          NUM_VOICES   = 4,
  parameter int          SAMPLE_WIDTH = 32,
  parameter int          SEL_WIDTH    = 4,
  parameter logic [14:0] BASE_HALF    = 15'd3000,
  parameter int          DIV_WIDTH    = SEL_WIDTH + 15,
  parameter int          AMPLITUDE    = 10000000,
  parameter int          DUR_WIDTH    = 16
) (
  input  logic                            CLOCK_50,
  input  logic                            reset,
  input  logic [NUM_VOICES-1:0]           trigger,
  input  logic [NUM_VOICES*SEL_WIDTH-1:0] sound_select,
  input  logic [NUM_VOICES*DUR_WIDTH-1:0] duration,
  input  logic [NUM_VOICES-1:0]           pan_left,
  input  logic [NUM_VOICES-1:0]           pan_right,
  sfx_tone_mixer_if.master                audio,
  output logic [NUM_VOICES-1:0]           voice_active
);

  localparam int MIX_W = SAMPLE_WIDTH + 4;
  localparam int SUM_W = SAMPLE_WIDTH + 5;
  localparam logic signed [MIX_W-1:0] AMP_POS = MIX_W'(AMPLITUDE);
  localparam logic signed [MIX_W-1:0] AMP_NEG = -AMP_POS;
  localparam logic signed [SUM_W-1:0] SAT_MAX = {6'b000000, {(SAMPLE_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = {6'b111111, {(SAMPLE_WIDTH-1){1'b0}}};

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} voice_state_t;

  voice_state_t           state_q   [NUM_VOICES];
  voice_state_t           state_d   [NUM_VOICES];
  logic                   phase_q   [NUM_VOICES];
  logic                   phase_d   [NUM_VOICES];
  logic [DIV_WIDTH-1:0]   counter_q [NUM_VOICES];
  logic [DIV_WIDTH-1:0]   counter_d [NUM_VOICES];
  logic [DUR_WIDTH-1:0]   remain_q  [NUM_VOICES];
  logic [DUR_WIDTH-1:0]   remain_d  [NUM_VOICES];
  logic signed [MIX_W-1:0] mix_l_q, mix_r_q, mix_l_d, mix_r_d;
  logic signed [MIX_W-1:0] mix_l_eff, mix_r_eff;
  logic signed [SUM_W-1:0] sum_l, sum_r;
  logic                    xfer;

  assign xfer                  = audio.audio_in_available & audio.audio_out_allowed & ~reset;
  assign audio.read_audio_in   = xfer;
  assign audio.write_audio_out = xfer;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        state_q[v]   <= IDLE;
        phase_q[v]   <= 1'b0;
        counter_q[v] <= '0;
        remain_q[v]  <= '0;
      end
      mix_l_q <= '0;
      mix_r_q <= '0;
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        state_q[v]   <= state_d[v];
        phase_q[v]   <= phase_d[v];
        counter_q[v] <= counter_d[v];
        remain_q[v]  <= remain_d[v];
      end
      mix_l_q <= mix_l_d;
      mix_r_q <= mix_r_d;
    end
  end

  always_comb begin
    mix_l_d = '0;
    mix_r_d = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      logic [SEL_WIDTH-1:0]    sel;
      logic [DUR_WIDTH-1:0]    dur;
      logic [DIV_WIDTH-1:0]    half;
      logic signed [MIX_W-1:0] contrib;
      sel          = sound_select[v*SEL_WIDTH +: SEL_WIDTH];
      dur          = duration[v*DUR_WIDTH +: DUR_WIDTH];
      half         = DIV_WIDTH'({sel, BASE_HALF});
      contrib      = '0;
      state_d[v]   = state_q[v];
      phase_d[v]   = phase_q[v];
      counter_d[v] = counter_q[v];
      remain_d[v]  = remain_q[v];
      case (state_q[v])
        IDLE: begin
          if (trigger[v] && dur != '0 && sel != '0) begin
            state_d[v]   = PLAY;
            remain_d[v]  = dur;
            counter_d[v] = '0;
            phase_d[v]   = 1'b1;
          end
        end
        PLAY: begin
          contrib = phase_q[v] ? AMP_POS : AMP_NEG;
          // >= lets a shortened period take effect at once instead of wrapping
          if (counter_q[v] >= half) begin
            counter_d[v] = '0;
            phase_d[v]   = ~phase_q[v];
          end else begin
            counter_d[v] = counter_q[v] + DIV_WIDTH'(1);
          end
          // retrigger reloads only the length so the waveform carries on without a click
          if (sel == '0) begin
            state_d[v] = IDLE;
          end else if (trigger[v] && dur != '0) begin
            remain_d[v] = dur;
          end else if (xfer) begin
            if (remain_q[v] == DUR_WIDTH'(1)) state_d[v] = IDLE;
            remain_d[v] = remain_q[v] - DUR_WIDTH'(1);
          end
        end
        default: state_d[v] = IDLE;
      endcase
      if (pan_left[v])  mix_l_d = mix_l_d + contrib;
      if (pan_right[v]) mix_r_d = mix_r_d + contrib;
    end
  end

  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) voice_active[v] = (state_q[v] == PLAY);
  end

  function automatic logic [SAMPLE_WIDTH-1:0] saturate(input logic signed [SUM_W-1:0] x);
    logic [SAMPLE_WIDTH-1:0] r;
    if (x > SAT_MAX)      r = SAT_MAX[SAMPLE_WIDTH-1:0];
    else if (x < SAT_MIN) r = SAT_MIN[SAMPLE_WIDTH-1:0];
    else                  r = x[SAMPLE_WIDTH-1:0];
    return r;
  endfunction

  // mix is masked during reset so the codec stream passes straight through
  assign mix_l_eff = reset ? '0 : mix_l_q;
  assign mix_r_eff = reset ? '0 : mix_r_q;
  assign sum_l     = SUM_W'($signed(audio.left_channel_audio_in))  + SUM_W'(mix_l_eff);
  assign sum_r     = SUM_W'($signed(audio.right_channel_audio_in)) + SUM_W'(mix_r_eff);

  assign audio.left_channel_audio_out  = saturate(sum_l);
  assign audio.right_channel_audio_out = saturate(sum_r);

endmodule
